float_mul_nb: RTL



---
 rtl/float_pkg.sv | 34 +++
 rtl/float_round_pack.sv | 47 ++++
 rtl/float_mul_nb.sv | 122 ++++++++++++
 3 files changed

// File: rtl/float_pkg.sv
// Shared binary32 definitions for the float_mul_nb / float_add_nb datapath.
package float_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } float32_t;

  localparam int          FLOAT_BIAS    = 127;
  localparam logic [31:0] FLOAT_QNAN    = 32'h7FC0_0000;
  localparam logic [7:0]  FLOAT_EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    FC_ZERO = 2'd0,
    FC_NORM = 2'd1,
    FC_INF  = 2'd2,
    FC_NAN  = 2'd3
  } fclass_t;

  // Denormals are classified as zero (flush-to-zero on input).
  function automatic fclass_t classify(input float32_t f);
    fclass_t c;
    if (f.exp == FLOAT_EXP_MAX) begin
      c = (f.frac != 23'd0) ? FC_NAN : FC_INF;
    end else if (f.exp == 8'd0) begin
      c = FC_ZERO;
    end else begin
      c = FC_NORM;
    end
    return c;
  endfunction

endpackage

// File: rtl/float_round_pack.sv
// Combinational round-to-nearest-even, range check and binary32 packing.
module float_round_pack
  import float_pkg::*;
(
  input  logic              sign,
  input  logic signed [9:0] exponent,
  input  logic [23:0]       mantissa,
  input  logic              guard,
  input  logic              sticky,
  input  fclass_t           fclass,
  output logic [31:0]       result
);

  logic              round_up_s;
  logic [24:0]       mant_rnd_s;
  logic signed [9:0] exp_rnd_s;
  logic [22:0]       frac_s;

  // Round, renormalise on carry-out, then select special or normal encoding.
  always_comb begin
    round_up_s = guard & (sticky | mantissa[0]);
    mant_rnd_s = {1'b0, mantissa} + {24'd0, round_up_s};
    if (mant_rnd_s[24]) begin
      exp_rnd_s = exponent + 10'sd1;
      frac_s    = mant_rnd_s[23:1];
    end else begin
      exp_rnd_s = exponent;
      frac_s    = mant_rnd_s[22:0];
    end
    case (fclass)
      FC_NAN:  result = FLOAT_QNAN;
      FC_INF:  result = {sign, FLOAT_EXP_MAX, 23'd0};
      FC_ZERO: result = {sign, 31'd0};
      FC_NORM: begin
        if (exp_rnd_s >= 10'sd255) begin
          result = {sign, FLOAT_EXP_MAX, 23'd0};
        end else if (exp_rnd_s <= 10'sd0) begin
          result = {sign, 31'd0};
        end else begin
          result = {sign, exp_rnd_s[7:0], frac_s};
        end
      end
      default: result = FLOAT_QNAN;
    endcase
  end

endmodule

// File: rtl/float_mul_nb.sv
// Three-stage streaming binary32 multiplier: classify, multiply, round/pack.
module float_mul_nb
  import float_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] din1,
  input  logic [31:0] din2,
  input  logic        din_valid,
  output logic [31:0] dout,
  output logic        dout_valid
);

  float32_t          a_s, b_s;
  fclass_t           ca_s, cb_s, cls_s;
  logic signed [9:0] exp_sum_s;

  logic              v1_r, sign1_r;
  logic signed [9:0] exp1_r;
  logic [23:0]       ma1_r, mb1_r;
  fclass_t           cls1_r;

  logic              v2_r, sign2_r;
  logic signed [9:0] exp2_r;
  logic [47:0]       prod2_r;
  fclass_t           cls2_r;

  logic signed [9:0] exp_n_s;
  logic [23:0]       mant_n_s;
  logic              guard_s, sticky_s;
  logic [31:0]       packed_s;
  logic [31:0]       dout_r;
  logic              dout_valid_r;

  // S1 classification: NaN and Inf*0 outrank Inf, which outranks zero.
  always_comb begin
    a_s       = float32_t'(din1);
    b_s       = float32_t'(din2);
    ca_s      = classify(a_s);
    cb_s      = classify(b_s);
    exp_sum_s = $signed({2'b00, a_s.exp}) + $signed({2'b00, b_s.exp}) - 10'(FLOAT_BIAS);
    if ((ca_s == FC_NAN) || (cb_s == FC_NAN) ||
        ((ca_s == FC_INF) && (cb_s == FC_ZERO)) ||
        ((ca_s == FC_ZERO) && (cb_s == FC_INF))) begin
      cls_s = FC_NAN;
    end else if ((ca_s == FC_INF) || (cb_s == FC_INF)) begin
      cls_s = FC_INF;
    end else if ((ca_s == FC_ZERO) || (cb_s == FC_ZERO)) begin
      cls_s = FC_ZERO;
    end else begin
      cls_s = FC_NORM;
    end
  end

  // Pipeline registers; valids always shift, data only loads behind a valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_r         <= 1'b0;
      sign1_r      <= 1'b0;
      exp1_r       <= 10'sd0;
      ma1_r        <= 24'd0;
      mb1_r        <= 24'd0;
      cls1_r       <= FC_ZERO;
      v2_r         <= 1'b0;
      sign2_r      <= 1'b0;
      exp2_r       <= 10'sd0;
      prod2_r      <= 48'd0;
      cls2_r       <= FC_ZERO;
      dout_r       <= 32'd0;
      dout_valid_r <= 1'b0;
    end else begin
      v1_r         <= din_valid;
      v2_r         <= v1_r;
      dout_valid_r <= v2_r;
      if (din_valid) begin
        sign1_r <= a_s.sign ^ b_s.sign;
        exp1_r  <= exp_sum_s;
        ma1_r   <= {1'b1, a_s.frac};
        mb1_r   <= {1'b1, b_s.frac};
        cls1_r  <= cls_s;
      end
      if (v1_r) begin
        sign2_r <= sign1_r;
        exp2_r  <= exp1_r;
        prod2_r <= {24'd0, ma1_r} * {24'd0, mb1_r};
        cls2_r  <= cls1_r;
      end
      if (v2_r) begin
        dout_r <= packed_s;
      end
    end
  end

  // S3 normalisation: product lies in [1,4), so at most one right shift.
  always_comb begin
    if (prod2_r[47]) begin
      mant_n_s = prod2_r[47:24];
      guard_s  = prod2_r[23];
      sticky_s = |prod2_r[22:0];
      exp_n_s  = exp2_r + 10'sd1;
    end else begin
      mant_n_s = prod2_r[46:23];
      guard_s  = prod2_r[22];
      sticky_s = |prod2_r[21:0];
      exp_n_s  = exp2_r;
    end
  end

  float_round_pack u_round_pack (
    .sign     (sign2_r),
    .exponent (exp_n_s),
    .mantissa (mant_n_s),
    .guard    (guard_s),
    .sticky   (sticky_s),
    .fclass   (cls2_r),
    .result   (packed_s)
  );

  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;

endmodule
